// File: rtl/jk_cmd_seq.sv
// jk_cmd_seq: queues timed J/K drive commands, replays them onto a downstream
// JK flip-flop and checks the flop's q against a local model.
module jk_cmd_seq #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             j,
  output logic             k,
  input  logic             q_fb,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef struct packed {
    logic [1:0]       op;
    logic [LEN_W-1:0] len;
  } cmd_t;

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_t;

  cmd_t             mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             j_q, j_d;
  logic             k_q, k_d;
  logic             done_q, done_d;
  logic             exp_q_q, exp_q_d;
  logic             exp_vld_q, exp_vld_d;
  logic             err_q, err_d;

  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  cmd_t             head;

  // Occupancy flags from the extra wrap bit on each pointer.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                 (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign push  = cmd_valid && !full;
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  assign wr_ptr_d = wr_ptr_q + PW'(push);
  assign rd_ptr_d = rd_ptr_q + PW'(pop);

  // FIFO storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= cmd_t'({cmd_op, cmd_len});
    end
  end

  // Sequencer next state: pop, load op/count, count down, chain without gaps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    j_d     = j_q;
    k_d     = k_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        j_d = 1'b0;
        k_d = 1'b0;
        if (!empty) begin
          pop        = 1'b1;
          state_d    = DRIVE;
          cnt_d      = head.len;
          {j_d, k_d} = head.op;
        end
      end
      DRIVE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - LEN_W'(1);
        end else if (!empty) begin
          pop        = 1'b1;
          cnt_d      = head.len;
          {j_d, k_d} = head.op;
        end else begin
          state_d = IDLE;
          j_d     = 1'b0;
          k_d     = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        j_d     = 1'b0;
        k_d     = 1'b0;
      end
    endcase
    // done lines up with the final drive cycle of whatever command is loaded.
    done_d = (state_d == DRIVE) && (cnt_d == '0);
  end

  // Downstream-q model and sticky mismatch flag, driven by the registered j/k.
  always_comb begin
    exp_q_d   = (j_q & ~exp_q_q) | (~k_q & exp_q_q);
    exp_vld_d = exp_vld_q | (j_q ^ k_q);
    err_d     = err_q | (exp_vld_q & (q_fb ^ exp_q_q));
  end

  // State register; reset wins over any push, pop or drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      j_q       <= 1'b0;
      k_q       <= 1'b0;
      done_q    <= 1'b0;
      exp_q_q   <= 1'b0;
      exp_vld_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      j_q       <= j_d;
      k_q       <= k_d;
      done_q    <= done_d;
      exp_q_q   <= exp_q_d;
      exp_vld_q <= exp_vld_d;
      err_q     <= err_d;
    end
  end

  assign cmd_ready = !full;
  assign busy      = (state_q == DRIVE) || !empty;
  assign j         = j_q;
  assign k         = k_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_jk_cmd_seq.sv
// tb_jk_cmd_seq: directed vectors for jk_cmd_seq with a downstream JK flop.
module tb_jk_cmd_seq;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_len;
  logic       j;
  logic       k;
  logic       q_fb;
  logic       busy;
  logic       done;
  logic       err;

  logic       dq;
  logic       q_rnd;
  logic [1:0] q_mode;   // 0: real flop, 1: stuck at 0, 2: random

  int n_cmp;
  int n_err;

  jk_cmd_seq #(.DEPTH(4), .LEN_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .j         (j),
    .k         (k),
    .q_fb      (q_fb),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream JK flip-flop and an arbitrary-q source.
  always @(posedge clk) begin
    if (rst) dq <= 1'b0;
    else     dq <= (j & ~dq) | (~k & dq);
    q_rnd <= 1'($urandom);
  end

  assign q_fb = (q_mode == 2'd0) ? dq : (q_mode == 2'd1) ? 1'b0 : q_rnd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] op, input logic [3:0] len);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_len   = 4'd0;
    q_mode    = 2'd0;
    rst       = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [1:0] exp_jk2   [7] = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b01};
  logic       exp_done2 [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [1:0] exp_jk3   [4] = '{2'b10, 2'b01, 2'b11, 2'b10};

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    q_mode    = 2'd0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_len   = 4'd0;
    rst       = 1'b1;

    // Reset state
    do_reset();
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_jk",    32'({j, k}), 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_err",   32'(err), 0);

    // Single set, len 2: accepted at N, drives N+2..N+4
    push(2'b10, 4'd2);
    tick();
    cmd_valid = 1'b0;
    chk("t1_jk_n1",   32'({j, k}), 0);
    chk("t1_busy_n1", 32'(busy), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_jk",   32'({j, k}), 32'(2'b10));
      chk("t1_done", 32'(done), 32'(i == 2));
    end
    tick();
    chk("t1_jk_n5",   32'({j, k}), 0);
    chk("t1_busy_n5", 32'(busy), 0);
    chk("t1_done_n5", 32'(done), 0);

    // Back-to-back set(0), toggle(3), reset(1)
    push(2'b10, 4'd0);
    tick();
    push(2'b11, 4'd3);
    chk("t2_jk_pre", 32'({j, k}), 0);
    tick();
    push(2'b01, 4'd1);
    for (int i = 0; i < 7; i++) begin
      chk("t2_jk",   32'({j, k}), 32'(exp_jk2[i]));
      chk("t2_done", 32'(done), 32'(exp_done2[i]));
      tick();
      cmd_valid = 1'b0;
    end
    chk("t2_jk_end",   32'({j, k}), 0);
    chk("t2_busy_end", 32'(busy), 0);

    // Fill FIFO behind a long command, refuse a 5th, then drain in order
    push(2'b10, 4'd15);
    tick();
    push(2'b10, 4'd0);
    tick();
    push(2'b01, 4'd0);
    tick();
    push(2'b11, 4'd0);
    tick();
    push(2'b10, 4'd0);
    chk("t3_ready_3", 32'(cmd_ready), 1);
    tick();
    push(2'b11, 4'd5);
    for (int i = 0; i < 5; i++) begin
      chk("t3_full", 32'(cmd_ready), 0);
      tick();
    end
    cmd_valid = 1'b0;
    repeat (7) tick();
    chk("t3_ready_last", 32'(cmd_ready), 0);
    chk("t3_done_long",  32'(done), 1);
    tick();
    chk("t3_ready_pop", 32'(cmd_ready), 1);
    for (int i = 0; i < 4; i++) begin
      chk("t3_jk",   32'({j, k}), 32'(exp_jk3[i]));
      chk("t3_done", 32'(done), 1);
      tick();
    end
    chk("t3_jk_end",   32'({j, k}), 0);
    chk("t3_busy_end", 32'(busy), 0);
    chk("t3_err",      32'(err), 0);

    // Correct downstream flop: set then toggle(2), no error
    do_reset();
    push(2'b10, 4'd0);
    tick();
    push(2'b11, 4'd2);
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("t4_err_ok", 32'(err), 0);
      tick();
    end

    // q_fb stuck at 0 after the set: err one cycle later, sticky
    do_reset();
    push(2'b10, 4'd0);
    tick();
    push(2'b11, 4'd2);
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 1) q_mode = 2'd1;
      chk("t4_err_stuck", 32'(err), 32'(i >= 2));
      tick();
    end
    q_mode = 2'd0;
    chk("t4_err_sticky", 32'(err), 1);

    // Toggle/hold only from reset with arbitrary q_fb
    do_reset();
    q_mode = 2'd2;
    push(2'b11, 4'd3);
    tick();
    push(2'b00, 4'd1);
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("t5_err",     32'(err), 0);
      chk("t5_exp_vld", 32'(dut.exp_vld_q), 0);
      tick();
    end
    q_mode = 2'd0;

    // Reset mid-DRIVE with two commands queued
    do_reset();
    push(2'b10, 4'd7);
    tick();
    push(2'b11, 4'd3);
    tick();
    push(2'b01, 4'd3);
    tick();
    cmd_valid = 1'b0;
    chk("t6_jk_pre",   32'({j, k}), 32'(2'b10));
    chk("t6_busy_pre", 32'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_jk",    32'({j, k}), 0);
    chk("t6_busy",  32'(busy), 0);
    chk("t6_ready", 32'(cmd_ready), 1);
    chk("t6_done",  32'(done), 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("t6_jk_after",   32'({j, k}), 0);
      chk("t6_busy_after", 32'(busy), 0);
      chk("t6_done_after", 32'(done), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/jk_cmd_seq.md
JK_CMD_SEQ -- requirements
Module: jk_cmd_seq

Interface
REQ-001 The block SHALL take parameter DEPTH, default 4: command FIFO depth in entries, a power of two and at least 2.
REQ-002 The block SHALL take parameter LEN_W, default 4: width of the per-command repeat field.
REQ-003 The block SHALL provide port clk  in  1  the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL provide port rst  in  1  synchronous, active-high reset.
REQ-005 The block SHALL provide port cmd_valid  in  1  command offered.
REQ-006 The block SHALL provide port cmd_ready  out  1  command FIFO can accept.
REQ-007 The block SHALL provide port cmd_op  in  2  operation: 00 hold, 01 reset, 10 set, 11 toggle.
REQ-008 The block SHALL provide port cmd_len  in  LEN_W  drive duration minus one, in cycles.
REQ-009 The block SHALL provide port j  out  1  J drive to the downstream JK flip-flop.
REQ-010 The block SHALL provide port k  out  1  K drive to the downstream JK flip-flop.
REQ-011 The block SHALL provide port q_fb  in  1  q fed back from the downstream JK flip-flop.
REQ-012 The block SHALL provide port busy  out  1  the FIFO is non-empty or a command is executing.
REQ-013 The block SHALL provide port done  out  1  one-cycle pulse on the last drive cycle of each command.
REQ-014 The block SHALL provide port err  out  1  sticky q_fb mismatch flag.

Function
REQ-015 A command SHALL be accepted in any cycle where cmd_valid and cmd_ready are both 1; cmd_op and cmd_len SHALL be captured into the FIFO tail.
REQ-016 cmd_ready SHALL be 0 exactly when the FIFO holds DEPTH entries; a pop in the same cycle SHALL NOT raise cmd_ready combinationally.
REQ-017 When not full, a push and a pop in the same cycle SHALL both take effect, and occupancy SHALL be unchanged.
REQ-018 FIFO pointers SHALL wrap modulo DEPTH, and full and empty SHALL be distinguishable; entry order SHALL be strictly FIFO.
REQ-019 The FSM SHALL have two states, IDLE and DRIVE; j and k SHALL be registered outputs.
REQ-020 In IDLE with the FIFO non-empty, the FSM SHALL pop the head, load the op, load cnt with cmd_len, and go to DRIVE; j/k SHALL take the op values from the next cycle.
REQ-021 Op mapping {j,k} SHALL be: hold 00, reset 01, set 10, toggle 11.
REQ-022 In DRIVE, j/k SHALL hold the op values for exactly cmd_len+1 consecutive cycles; cnt SHALL decrement once per cycle.
REQ-023 On the DRIVE cycle with cnt==0, done SHALL be 1; if the FIFO is non-empty, the next command SHALL be popped so that its j/k follow with no gap cycle; otherwise the FSM SHALL return to IDLE and j/k SHALL be 00 from the next cycle.
REQ-024 Latency: a command accepted in cycle N with the FIFO empty and the FSM in IDLE SHALL drive j/k in cycles N+2 .. N+2+cmd_len.
REQ-025 cmd_len = 0 SHALL produce a single drive cycle, with done asserted in that same cycle.
REQ-026 In IDLE, j/k SHALL be 00 (hold), so the downstream q is never disturbed.
REQ-027 The checker SHALL keep a model bit exp_q and a flag exp_vld. At each edge, exp_q SHALL become (j & ~exp_q) | (~k & exp_q) using the driven j/k. exp_vld SHALL be set at the first edge where j != k. Hold and toggle SHALL NOT set exp_vld.
REQ-028 When exp_vld is 1, any cycle with q_fb != exp_q SHALL set err, and err SHALL remain 1 until rst.
REQ-029 busy SHALL equal (state==DRIVE) | FIFO non-empty, as a registered or equivalent glitch-free function of state.

Reset
REQ-030 While rst is 1 at an edge, the following SHALL all be cleared: FIFO empty, pointers 0, FSM IDLE, cnt 0, j=0, k=0, done=0, err=0, exp_q=0, exp_vld=0.
REQ-031 cmd_ready SHALL be 1 in the first cycle after reset.
REQ-032 rst SHALL take priority over a push, pop, or drive in the same cycle.
REQ-033 Reset in the middle of a command SHALL abort it, discard all queued commands, and make no done pulse.

Verification
REQ-034 Bench SHALL cover: single set with len 2, accepted at N -> j/k=10 in N+2..N+4, done at N+4, j/k=00 at N+5, busy cleared by N+5.
REQ-035 Bench SHALL cover: back-to-back set(len 0), toggle(len 3), reset(len 1) -> j/k sequence 10,11,11,11,11,01,01 with no gaps and done in cycles 1, 5, 7.
REQ-036 Bench SHALL cover: 4 pushes with no drain and DEPTH=4 -> cmd_ready=0 after the 4th; a 5th offer is not accepted; cmd_ready returns to 1 the cycle after the first pop.
REQ-037 Bench SHALL cover: downstream JK flop connected correctly, set then toggle(len 2) -> err stays 0; with q_fb forced to 0 after the set -> err=1 one cycle after the divergence, and it stays set.
REQ-038 Bench SHALL cover: toggle only from reset, with q_fb arbitrary -> exp_vld=0 and err=0 throughout.
REQ-039 Bench SHALL cover: rst asserted mid-DRIVE with 2 entries queued -> j/k=00, busy=0, cmd_ready=1, done=0 next cycle, and no queued command is executed afterwards.
